// File: rtl/pc_reg_pkg.sv
// Shared CPU constants for the fetch path.
// Used by pc_reg, the fetch adder and the jump-target shifter.
package pc_reg_pkg;

    localparam int          ADDR_W             = 32;
    localparam int          INSTR_BYTES        = 4;
    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_reg_if.sv
// PC register bus: next-PC and enable in, current PC, fall-through and flag out.
// master = PC-update logic, slave = pc_reg.
interface pc_reg_if
    import pc_reg_pkg::*;
#(
    parameter int WIDTH = ADDR_W
);

    logic             en;
    logic [WIDTH-1:0] pcin;
    logic [WIDTH-1:0] pcout;
    logic [WIDTH-1:0] pc_plus4;
    logic             misaligned;

    modport master (
        output en,
        output pcin,
        input  pcout,
        input  pc_plus4,
        input  misaligned
    );

    modport slave (
        input  en,
        input  pcin,
        output pcout,
        output pc_plus4,
        output misaligned
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter: registered PC with load/hold, inline +INCR, sticky misalign flag.
// Ports: clk, reset (sync, active-low), bus (slave: en, pcin -> pcout, pc_plus4, misaligned).
module pc_reg
    import pc_reg_pkg::*;
#(
    parameter int               WIDTH      = ADDR_W,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(RESET_ADDR_DEFAULT),
    parameter int               INCR       = INSTR_BYTES
) (
    input  logic      clk,
    input  logic      reset,
    pc_reg_if.slave   bus
);

    logic [WIDTH-1:0] pc_q;
    logic             mis_q;

    // Low two bits are dropped on load; any non-zero ones latch the flag
    // until the next reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= RESET_ADDR;
            mis_q <= 1'b0;
        end else if (bus.en) begin
            pc_q  <= {bus.pcin[WIDTH-1:2], 2'b00};
            mis_q <= mis_q | (|bus.pcin[1:0]);
        end
    end

    assign bus.pcout      = pc_q;
    assign bus.pc_plus4   = pc_q + WIDTH'(INCR);
    assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_pc_reg.sv
// Directed bench for pc_reg with a spec-level model checked every cycle.
// Two instances share stimulus; they differ only in RESET_ADDR.
module tb_pc_reg;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pc_reg_if #(.WIDTH(32)) bus_a ();
    pc_reg_if #(.WIDTH(32)) bus_b ();

    pc_reg #(
        .WIDTH(32), .RESET_ADDR(32'h0000_0000), .INCR(4)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );

    pc_reg #(
        .WIDTH(32), .RESET_ADDR(32'h0040_0000), .INCR(4)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    logic        en;
    logic [31:0] pcin;

    assign bus_a.en   = en;
    assign bus_a.pcin = pcin;
    assign bus_b.en   = en;
    assign bus_b.pcin = pcin;

    int tests  = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Spec model: value per reset address, flag as "any misaligned load since reset".
    logic        m_valid = 1'b0;
    logic [31:0] m_pc_a, m_pc_b;
    logic        m_mis;

    always @(posedge clk) begin
        if (reset == 1'b0) begin
            m_valid <= 1'b1;
            m_pc_a  <= 32'h0000_0000;
            m_pc_b  <= 32'h0040_0000;
            m_mis   <= 1'b0;
        end else if (en) begin
            m_pc_a <= pcin & ~32'd3;
            m_pc_b <= pcin & ~32'd3;
            if ((pcin % 4) != 0) m_mis <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc_a",   bus_a.pcout,             m_pc_a);
            chk("model_p4_a",   bus_a.pc_plus4,          m_pc_a + 32'd4);
            chk("model_mis_a",  {31'd0, bus_a.misaligned}, {31'd0, m_mis});
            chk("model_pc_b",   bus_b.pcout,             m_pc_b);
            chk("model_p4_b",   bus_b.pc_plus4,          m_pc_b + 32'd4);
            chk("model_mis_b",  {31'd0, bus_b.misaligned}, {31'd0, m_mis});
        end
    end

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        pcin  = 32'h1234_5678;
        tick();
        tick();
        chk("rst_pc",  bus_a.pcout, 32'h0);
        chk("rst_p4",  bus_a.pc_plus4, 32'h4);
        chk("rst_mis", {31'd0, bus_a.misaligned}, 32'd0);
        chk("rst_pc_b", bus_b.pcout, 32'h0040_0000);

        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pcin = bus_a.pc_plus4;
            tick();
            chk("seq_pc", bus_a.pcout, 32'(4 * (i + 1)));
        end

        pcin = 32'h40;
        tick();
        chk("stall_ld", bus_a.pcout, 32'h40);
        en   = 1'b0;
        pcin = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", bus_a.pcout, 32'h40);
        end
        en = 1'b1;
        tick();
        chk("stall_rel", bus_a.pcout, 32'h80);

        pcin = 32'h0000_0103;
        tick();
        chk("mis_pc",  bus_a.pcout, 32'h100);
        chk("mis_set", {31'd0, bus_a.misaligned}, 32'd1);
        pcin = 32'h200;
        tick();
        chk("mis_pc2",    bus_a.pcout, 32'h200);
        chk("mis_sticky", {31'd0, bus_a.misaligned}, 32'd1);
        reset = 1'b0;
        tick();
        chk("mis_rst_pc", bus_a.pcout, 32'h0);
        chk("mis_clr",    {31'd0, bus_a.misaligned}, 32'd0);

        reset = 1'b1;
        pcin  = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pc", bus_a.pcout, 32'hFFFF_FFFC);
        chk("wrap_p4", bus_a.pc_plus4, 32'h0);

        pcin = 32'h1000;
        tick();
        chk("pre_rst", bus_a.pcout, 32'h1000);
        reset = 1'b0;
        pcin  = 32'hABCD_0000;
        tick();
        chk("prec_a", bus_a.pcout, 32'h0);
        chk("prec_b", bus_b.pcout, 32'h0040_0000);
        reset = 1'b1;
        pcin  = 32'h8;
        tick();
        chk("resume", bus_a.pcout, 32'h8);

        // Reset pulse entirely between edges must be ignored.
        pcin  = 32'h20;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        chk("glitch", bus_a.pcout, 32'h20);
        chk("glitch_b", bus_b.pcout, 32'h20);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
